// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package common;

  // Default word-address width of the instruction memory
  localparam int IMEM_ADDR_W = 14;

  // Arbiter mode: BOOT serves only the loader, RUN arbitrates both requesters
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_type;

endpackage

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter between fetch (reads) and the
// program loader (writes), with starvation-bounded loader priority.
// Optional feature macro: IMEM_ARB_BOOT_HOLD_EN keeps fetch off in a BOOT
// phase until the loader pulses load_done. Without it, reset enters RUN.
module imem_port_arbiter
  import common::*;
#(
  parameter int ADDR_W          = IMEM_ADDR_W,
  parameter int MAX_LOAD_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              fetch_kill,
  output logic              fetch_gnt,
  output logic              fetch_stall,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [31:0]       load_wdata,
  output logic              load_gnt,
  input  logic              load_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LOAD_STREAK);

  logic       run;
  logic [3:0] streak_q, streak_d;
  logic       rd_pending_q;
  logic       unused_ok;

`ifdef IMEM_ARB_BOOT_HOLD_EN
  arb_state_type state_q, state_d;

  // Next mode: leave BOOT on the loader's end-of-image pulse; RUN is terminal
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && load_done) begin
      state_d = RUN;
    end
  end

  // Mode register, reset back into BOOT so the loader must re-issue load_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  assign run = (state_q == RUN);
  assign unused_ok = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0],
                       load_addr[31:ADDR_W+2], load_addr[1:0]};
`else
  assign run = 1'b1;
  assign unused_ok = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0],
                       load_addr[31:ADDR_W+2], load_addr[1:0], load_done};
`endif

  // Grant selection: loader has priority until it has starved fetch long enough
  always_comb begin
    load_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    if (!reset) begin
      if (!run) begin
        load_gnt = load_req;
      end else if (load_req && fetch_req) begin
        if (streak_q >= STREAK_MAX) begin
          fetch_gnt = 1'b1;
        end else begin
          load_gnt = 1'b1;
        end
      end else begin
        load_gnt  = load_req;
        fetch_gnt = fetch_req;
      end
    end
  end

  // Streak of loader wins seen by a waiting fetch, saturating at the limit
  always_comb begin
    streak_d = streak_q;
    if (!fetch_req || fetch_gnt) begin
      streak_d = 4'd0;
    end else if (load_gnt && streak_q < STREAK_MAX) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // Memory port drive from the winner; idle cycles put zeros on the bus
  always_comb begin
    mem_en    = fetch_gnt | load_gnt;
    mem_we    = load_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_addr = fetch_addr[ADDR_W+1:2];
    end else if (load_gnt) begin
      mem_addr  = load_addr[ADDR_W+1:2];
      mem_wdata = load_wdata;
    end
  end

  // Streak counter and read-response tracking; reset drops any pending read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q     <= 4'd0;
      rd_pending_q <= 1'b0;
    end else begin
      streak_q     <= streak_d;
      rd_pending_q <= fetch_gnt;
    end
  end

  // Response path: a kill in the response cycle hides the returning word
  always_comb begin
    fetch_stall  = fetch_req && !fetch_gnt;
    fetch_rvalid = rd_pending_q && !fetch_kill;
    fetch_rdata  = fetch_rvalid ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: expected read words are queued when a
// fetch grant is driven and compared when the response cycle arrives.
// Honours IMEM_ARB_BOOT_HOLD_EN for the boot-hold expectations.
module tb_imem_port_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, fetch_kill, load_req, load_done;
  logic [31:0]   fetch_addr, load_addr, load_wdata;
  logic          fetch_gnt, fetch_stall, fetch_rvalid, load_gnt;
  logic [31:0]   fetch_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] memArr [0:255];
  logic [31:0] refMem [0:255];
  logic [31:0] respQ [$];
  int checks = 0;
  int errors = 0;

  imem_port_arbiter #(.ADDR_W(AW), .MAX_LOAD_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_kill(fetch_kill),
    .fetch_gnt(fetch_gnt), .fetch_stall(fetch_stall),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_gnt(load_gnt), .load_done(load_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Write-first synchronous memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        memArr[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem_wdata;
      end else begin
        mem_rdata <= memArr[mem_addr[7:0]];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One cycle: drive at negedge, check response and grant outputs just after
  task automatic applyStimulus(input logic fr, input logic [31:0] fa,
                               input logic fk, input logic lr,
                               input logic [31:0] la, input logic [31:0] lw,
                               input logic ld, input logic expF,
                               input logic expL);
    logic [31:0] e;
    logic [AW-1:0] expAddr;
    @(negedge clk);
    fetch_req = fr; fetch_addr = fa; fetch_kill = fk;
    load_req = lr; load_addr = la; load_wdata = lw; load_done = ld;
    #1;
    if (respQ.size() > 0) begin
      e = respQ.pop_front();
      checkOutput("rvalid", {31'd0, fetch_rvalid}, fk ? 32'd0 : 32'd1);
      checkOutput("rdata", fetch_rdata, fk ? 32'd0 : e);
    end else begin
      checkOutput("rvalidIdle", {31'd0, fetch_rvalid}, 32'd0);
    end
    expAddr = expF ? fa[AW+1:2] : (expL ? la[AW+1:2] : '0);
    checkOutput("fetchGnt", {31'd0, fetch_gnt}, {31'd0, expF});
    checkOutput("loadGnt", {31'd0, load_gnt}, {31'd0, expL});
    checkOutput("stall", {31'd0, fetch_stall}, {31'd0, fr && !expF});
    checkOutput("memEn", {31'd0, mem_en}, {31'd0, expF || expL});
    checkOutput("memWe", {31'd0, mem_we}, {31'd0, expL});
    checkOutput("memAddr", {18'd0, mem_addr}, {18'd0, expAddr});
    checkOutput("memWdata", mem_wdata, expL ? lw : 32'd0);
    if (expF) respQ.push_back(refMem[fa[9:2]]);
    if (expL) refMem[la[9:2]] = lw;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic bootHold;
`ifdef IMEM_ARB_BOOT_HOLD_EN
    bootHold = 1'b1;
`else
    bootHold = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      memArr[i] = 32'd0;
      refMem[i] = 32'd0;
    end
    mem_rdata = 32'd0;
    reset = 1'b1;
    fetch_req = 0; fetch_addr = 0; fetch_kill = 0;
    load_req = 0; load_addr = 0; load_wdata = 0; load_done = 0;
    @(negedge clk); @(negedge clk); #1;
    checkOutput("rstFetchGnt", {31'd0, fetch_gnt}, 32'd0);
    checkOutput("rstLoadGnt", {31'd0, load_gnt}, 32'd0);
    checkOutput("rstMemEn", {31'd0, mem_en}, 32'd0);
    checkOutput("rstRvalid", {31'd0, fetch_rvalid}, 32'd0);
    checkOutput("rstStall", {31'd0, fetch_stall}, 32'd0);
    reset = 1'b0;

    // Boot hold: loader write wins over fetch, then load_done, then fetch
    applyStimulus(1, 32'h0, 0, 1, 32'h0, 32'h0000_0013, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 1, 0);
    idleCycle();

    // Preload words 1, 2, 5 and 16 through the loader alone
    applyStimulus(0, 0, 0, 1, 32'h4, 32'hA1A1_0001, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 32'h8, 32'hB2B2_0002, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 32'h40, 32'h1600_0016, 0, 0, 1);
    // Write then read the same word on consecutive cycles
    applyStimulus(0, 0, 0, 1, 32'h14, 32'h5555_AAAA, 0, 0, 1);
    applyStimulus(1, 32'h17, 0, 0, 0, 0, 0, 1, 0);

    // Streaming fetch of words 0, 1, 2 (byte offsets in bits [1:0] ignored)
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 32'h9, 0, 0, 0, 0, 0, 1, 0);
    idleCycle();

    // Starvation bound: both held, 4 loader grants then 1 fetch grant, twice
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'h40, 0, 1, 32'h80 + 32'(i * 4),
                    32'hC000_0000 + 32'(i), 0, (i % 5) == 4, (i % 5) != 4);
    end
    idleCycle();

    // Kill in the response cycle hides the word
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Kill in the grant cycle does not cancel that grant
    applyStimulus(1, 32'h8, 1, 0, 0, 0, 0, 1, 0);
    idleCycle();

    // Async reset between grant and response
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstRvalid", {31'd0, fetch_rvalid}, 32'd0);
    checkOutput("midRstFetchGnt", {31'd0, fetch_gnt}, 32'd0);
    checkOutput("midRstStall", {31'd0, fetch_stall}, 32'd1);
    #1;
    reset = 1'b0;
    respQ.delete();
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, !bootHold, 0);
    idleCycle();

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
